// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard unit.
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RS = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2} fwd_src_e;
  localparam int ZERO_REG = 0;
  localparam int LOAD_LAT_W = 3;
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: decode group, stage destinations and issue/forwarding results.
// HAZARD_PERF_EN adds the 32-bit performance counter outputs.
interface hazard_scoreboard_unit_if #(
  parameter int WAYS = 3,
  parameter int NUM_REGS = 32
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = $clog2(WAYS + 1);
  logic flush;
  logic [WAYS-1:0] id_valid, id_rd_mem, ex_valid, mem_valid;
  logic [WAYS-1:0][RW-1:0] id_rs1, id_rs2, id_dest, ex_dest, mem_dest;
  logic [WAYS-1:0][1:0] rs1_src, rs2_src;
  logic [WAYS-1:0][WW-1:0] rs1_way, rs2_way;
  logic [CW-1:0] issue_count;
  logic stall_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_load_use, perf_intra_group;
  modport master(output flush, id_valid, id_rd_mem, ex_valid, mem_valid, id_rs1, id_rs2, id_dest,
                 ex_dest, mem_dest, input rs1_src, rs2_src, rs1_way, rs2_way, issue_count,
                 stall_timeout, perf_stall_cycles, perf_load_use, perf_intra_group);
  modport slave(input flush, id_valid, id_rd_mem, ex_valid, mem_valid, id_rs1, id_rs2, id_dest,
                ex_dest, mem_dest, output rs1_src, rs2_src, rs1_way, rs2_way, issue_count,
                stall_timeout, perf_stall_cycles, perf_load_use, perf_intra_group);
`else
  modport master(output flush, id_valid, id_rd_mem, ex_valid, mem_valid, id_rs1, id_rs2, id_dest,
                 ex_dest, mem_dest, input rs1_src, rs2_src, rs1_way, rs2_way, issue_count,
                 stall_timeout);
  modport slave(input flush, id_valid, id_rd_mem, ex_valid, mem_valid, id_rs1, id_rs2, id_dest,
                ex_dest, mem_dest, output rs1_src, rs2_src, rs1_way, rs2_way, issue_count,
                stall_timeout);
`endif
endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// fwd_select: picks the youngest EX/MEM producer of one source register.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int WAYS = 3,
  parameter int RW = 5,
  parameter int WW = 2
) (
  input  logic [RW-1:0]            src_i,
  input  logic [WAYS-1:0]          ex_valid_i,
  input  logic [WAYS-1:0]          mem_valid_i,
  input  logic [WAYS-1:0][RW-1:0]  ex_dest_i,
  input  logic [WAYS-1:0][RW-1:0]  mem_dest_i,
  output fwd_src_e                 src_o,
  output logic [WW-1:0]            way_o
);
  // Later assignments win: MEM scanned first, then EX, each from way 0 upward.
  always_comb begin
    src_o = FWD_RS;
    way_o = '0;
    for (int i = 0; i < WAYS; i++)
      if (src_i != RW'(ZERO_REG) && mem_valid_i[i] && mem_dest_i[i] == src_i) begin
        src_o = FWD_MEM;
        way_o = WW'(i);
      end
    for (int i = 0; i < WAYS; i++)
      if (src_i != RW'(ZERO_REG) && ex_valid_i[i] && ex_dest_i[i] == src_i) begin
        src_o = FWD_EX;
        way_o = WW'(i);
      end
  end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: ID-stage forwarding selects, load-use scoreboard, issue limit and stall watchdog.
// HAZARD_PERF_EN adds stall/load-use/intra-group performance counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int WAYS = 3,
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int MAX_STALL = 15
) (
  input logic clk_i,
  input logic rst_ni,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = $clog2(WAYS + 1);
  localparam int SW = $clog2(MAX_STALL + 1);
  logic [LOAD_LAT_W-1:0] pend_q [NUM_REGS];
  logic [LOAD_LAT_W-1:0] pend_d [NUM_REGS];
  logic [SW-1:0] stall_q, stall_d;
  logic timeout_q, timeout_d;
  logic [WAYS-1:0] blk_ld, blk_dep;
  logic [CW-1:0] issue;
  fwd_src_e s1_src [WAYS];
  fwd_src_e s2_src [WAYS];
  logic [WW-1:0] s1_way [WAYS];
  logic [WW-1:0] s2_way [WAYS];
  genvar g;
  for (g = 0; g < WAYS; g++) begin : g_fwd
    fwd_select #(.WAYS(WAYS), .RW(RW), .WW(WW)) u_rs1 (
      .src_i(bus.id_rs1[g]), .ex_valid_i(bus.ex_valid), .mem_valid_i(bus.mem_valid),
      .ex_dest_i(bus.ex_dest), .mem_dest_i(bus.mem_dest), .src_o(s1_src[g]), .way_o(s1_way[g])
    );
    fwd_select #(.WAYS(WAYS), .RW(RW), .WW(WW)) u_rs2 (
      .src_i(bus.id_rs2[g]), .ex_valid_i(bus.ex_valid), .mem_valid_i(bus.mem_valid),
      .ex_dest_i(bus.ex_dest), .mem_dest_i(bus.mem_dest), .src_o(s2_src[g]), .way_o(s2_way[g])
    );
  end
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      bus.rs1_src[i] = s1_src[i];
      bus.rs2_src[i] = s2_src[i];
      bus.rs1_way[i] = s1_way[i];
      bus.rs2_way[i] = s2_way[i];
    end
  end
  // A matching nonzero earlier dest implies a nonzero source, so x0 never blocks.
  always_comb begin
    blk_ld = '0;
    blk_dep = '0;
    for (int i = 0; i < WAYS; i++) begin
      blk_ld[i] = bus.id_valid[i] &&
                  ((bus.id_rs1[i] != RW'(ZERO_REG) && pend_q[bus.id_rs1[i]] != '0) ||
                   (bus.id_rs2[i] != RW'(ZERO_REG) && pend_q[bus.id_rs2[i]] != '0));
      for (int j = 0; j < i; j++)
        blk_dep[i] = blk_dep[i] || (bus.id_valid[i] && bus.id_valid[j] &&
                     bus.id_dest[j] != RW'(ZERO_REG) &&
                     (bus.id_rs1[i] == bus.id_dest[j] || bus.id_rs2[i] == bus.id_dest[j]));
    end
  end
  always_comb begin
    issue = CW'(WAYS);
    for (int i = WAYS - 1; i >= 0; i--)
      issue = (blk_ld[i] || blk_dep[i]) ? CW'(i) : issue;
    issue = bus.flush ? '0 : issue;
  end
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      pend_d[r] = (bus.flush || pend_q[r] == '0) ? '0 : pend_q[r] - 1'b1;
    for (int i = 0; i < WAYS; i++)
      if (CW'(i) < issue && bus.id_valid[i] && bus.id_rd_mem[i] && bus.id_dest[i] != RW'(ZERO_REG))
        pend_d[bus.id_dest[i]] = LOAD_LAT_W'(LOAD_LAT);
  end
  assign stall_d = bus.flush ? '0 :
                   (bus.id_valid[0] && issue == '0) ?
                   ((stall_q == SW'(MAX_STALL)) ? stall_q : stall_q + 1'b1) : '0;
  assign timeout_d = !bus.flush && (timeout_q || stall_d == SW'(MAX_STALL));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      stall_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      stall_q <= stall_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.issue_count = issue;
  assign bus.stall_timeout = timeout_q;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_ld_q, perf_dep_q;
  logic stall_cyc, cause_ld, cause_dep;
  always_comb begin
    stall_cyc = 1'b0;
    cause_ld = 1'b0;
    cause_dep = 1'b0;
    for (int i = 0; i < WAYS; i++)
      if (CW'(i) == issue && bus.id_valid[i]) begin
        stall_cyc = 1'b1;
        cause_ld = blk_ld[i];
        cause_dep = blk_dep[i];
      end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_ld_q <= '0;
      perf_dep_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(stall_cyc);
      perf_ld_q <= perf_ld_q + 32'(cause_ld);
      perf_dep_q <= perf_dep_q + 32'(cause_dep);
    end
  end
  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_load_use = perf_ld_q;
  assign bus.perf_intra_group = perf_dep_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed scenarios plus random groups checked against a reference model.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;
  localparam int W = 3;
  localparam int NR = 32;
  localparam int LAT = 7;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int m_pend [NR];
  int m_stall;
  bit m_to;
  always #5 clk = ~clk;
  hazard_scoreboard_unit_if #(.WAYS(W), .NUM_REGS(NR)) bus ();
  hazard_scoreboard_unit #(.WAYS(W), .NUM_REGS(NR), .LOAD_LAT(LAT), .MAX_STALL(MAXS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic void model_clear();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_stall = 0;
    m_to = 0;
  endfunction
  function automatic bit src_blocked(input int i, input int s);
    if (s == 0) return 0;
    if (m_pend[s] > 0) return 1;
    for (int j = 0; j < i; j++)
      if (bus.id_valid[j] && int'(bus.id_dest[j]) == s) return 1;
    return 0;
  endfunction
  function automatic int exp_issue();
    if (bus.flush) return 0;
    for (int i = 0; i < W; i++)
      if (bus.id_valid[i] && (src_blocked(i, int'(bus.id_rs1[i])) || src_blocked(i, int'(bus.id_rs2[i]))))
        return i;
    return W;
  endfunction
  function automatic void exp_fwd(input int s, output int src, output int way);
    src = FWD_RS;
    way = 0;
    if (s == 0) return;
    for (int i = W - 1; i >= 0; i--)
      if (bus.ex_valid[i] && int'(bus.ex_dest[i]) == s) begin
        src = FWD_EX; way = i; return;
      end
    for (int i = W - 1; i >= 0; i--)
      if (bus.mem_valid[i] && int'(bus.mem_dest[i]) == s) begin
        src = FWD_MEM; way = i; return;
      end
  endfunction
  task automatic cycle();
    int iss, src, way;
    @(negedge clk);
    iss = exp_issue();
    check("issue_count", 32'(bus.issue_count), iss);
    check("stall_timeout", 32'(bus.stall_timeout), 32'(m_to));
    for (int i = 0; i < W; i++) begin
      exp_fwd(int'(bus.id_rs1[i]), src, way);
      check($sformatf("rs1_src[%0d]", i), 32'(bus.rs1_src[i]), src);
      if (src != FWD_RS) check($sformatf("rs1_way[%0d]", i), 32'(bus.rs1_way[i]), way);
      exp_fwd(int'(bus.id_rs2[i]), src, way);
      check($sformatf("rs2_src[%0d]", i), 32'(bus.rs2_src[i]), src);
      if (src != FWD_RS) check($sformatf("rs2_way[%0d]", i), 32'(bus.rs2_way[i]), way);
    end
    @(posedge clk);
    if (!rst_n || bus.flush) model_clear();
    else begin
      foreach (m_pend[r]) if (m_pend[r] > 0) m_pend[r]--;
      for (int i = 0; i < iss; i++)
        if (bus.id_valid[i] && bus.id_rd_mem[i] && bus.id_dest[i] != 0) m_pend[bus.id_dest[i]] = LAT;
      m_stall = (bus.id_valid[0] && iss == 0) ? ((m_stall < MAXS) ? m_stall + 1 : MAXS) : 0;
      if (m_stall == MAXS) m_to = 1;
    end
    #1;
  endtask
  task automatic clear_inputs();
    bus.flush = 0;
    bus.id_valid = '0; bus.id_rd_mem = '0; bus.ex_valid = '0; bus.mem_valid = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_dest = '0; bus.ex_dest = '0; bus.mem_dest = '0;
  endtask
  initial begin
    clear_inputs();
    model_clear();
    cycle();
    check("reset_timeout", 32'(bus.stall_timeout), 0);
    rst_n = 1;
    // load-use: load to x5, then a dependent read stalls until MEM can forward
    bus.id_valid = '1; bus.id_rd_mem[0] = 1; bus.id_dest[0] = 5; bus.id_dest[1] = 10; bus.id_dest[2] = 11;
    cycle();
    clear_inputs();
    bus.id_valid = '1; bus.id_rs1[0] = 5;
    repeat (LAT) cycle();
    bus.mem_valid[0] = 1; bus.mem_dest[0] = 5;
    cycle();
    clear_inputs(); bus.flush = 1;
    cycle();
    // intra-group dependence
    clear_inputs();
    bus.id_valid = '1; bus.id_dest[0] = 7; bus.id_rs1[1] = 1; bus.id_rs2[1] = 2; bus.id_dest[1] = 8; bus.id_rs2[2] = 7;
    cycle();
    bus.id_rs1[1] = 7;
    cycle();
    // x0 everywhere
    clear_inputs();
    bus.id_valid = '1; bus.id_rd_mem = '1; bus.ex_valid = '1; bus.mem_valid = '1;
    cycle();
    cycle();
    // EX beats MEM, highest way wins
    clear_inputs();
    bus.id_valid = '1; bus.ex_valid = 3'b011; bus.ex_dest[0] = 3; bus.ex_dest[1] = 3;
    bus.mem_valid[2] = 1; bus.mem_dest[2] = 3; bus.id_rs1[2] = 3;
    cycle();
    // flush clears a pending load
    clear_inputs();
    bus.id_valid[0] = 1; bus.id_rd_mem[0] = 1; bus.id_dest[0] = 9;
    cycle();
    clear_inputs();
    bus.flush = 1; bus.id_valid = '1; bus.id_rs1[0] = 9;
    cycle();
    bus.flush = 0;
    cycle();
    // watchdog: timeout is sticky until flush, then cleared by async reset
    clear_inputs();
    bus.id_valid[0] = 1; bus.id_rd_mem[0] = 1; bus.id_dest[0] = 20;
    cycle();
    clear_inputs();
    bus.id_valid[0] = 1; bus.id_rs1[0] = 20;
    repeat (6) cycle();
    check("timeout_set", 32'(bus.stall_timeout), 1);
    bus.flush = 1;
    cycle();
    bus.flush = 0; bus.id_rs1[0] = 0; bus.id_rd_mem[0] = 1; bus.id_dest[0] = 20;
    cycle();
    clear_inputs();
    bus.id_valid[0] = 1; bus.id_rs1[0] = 20;
    repeat (5) cycle();
    #2 rst_n = 0;
    #1 check("async_rst_timeout", 32'(bus.stall_timeout), 0);
    model_clear();
    cycle();
    rst_n = 1;
    // random groups over a small register window to provoke hazards
    repeat (500) begin
      bus.flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < W; i++) begin
        bus.id_valid[i] = ($urandom_range(0, 3) != 0);
        bus.id_rd_mem[i] = $urandom_range(0, 1);
        bus.ex_valid[i] = $urandom_range(0, 1);
        bus.mem_valid[i] = $urandom_range(0, 1);
        bus.id_rs1[i] = 5'($urandom_range(0, 7));
        bus.id_rs2[i] = 5'($urandom_range(0, 7));
        bus.id_dest[i] = 5'($urandom_range(0, 7));
        bus.ex_dest[i] = 5'($urandom_range(0, 7));
        bus.mem_dest[i] = 5'($urandom_range(0, 7));
      end
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the fixed 3-way ID-stage hazard/forwarding logic.
- Takes a WAYS-wide decode group and computes per-source forwarding selects from EX/MEM, plus how many leading ways may issue (issue_count; rollback = WAYS - issue_count).
- Owns a per-register load-pending scoreboard with a configurable load-use latency, so multi-cycle loads stall correctly.
- Adds a stall watchdog; sits between ID and the ID/EX pipeline register.

Parameters:
- WAYS, 3, superscalar width (1..8).
- NUM_REGS, 32, architectural registers; index width RW = $clog2(NUM_REGS).
- LOAD_LAT, 1, cycles a load's dest stays un-forwardable after issue (1..7).
- MAX_STALL, 15, consecutive zero-issue cycles before timeout.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  squash; clears scoreboard and stall counter
- id_valid  in  WAYS  way i holds an instruction
- id_rs1, id_rs2  in  WAYS x RW  source registers
- id_dest  in  WAYS x RW  destination register (ZERO_REG = none)
- id_rd_mem  in  WAYS  way i is a load
- ex_valid, mem_valid  in  WAYS  stage way valid
- ex_dest, mem_dest  in  WAYS x RW  stage destinations
- rs1_src, rs2_src  out  WAYS x FWD_SRC  RS / EX / MEM
- rs1_way, rs2_way  out  WAYS x $clog2(WAYS)  producing way
- issue_count  out  $clog2(WAYS+1)  leading ways allowed to issue
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- State: pend_cnt[NUM_REGS], 3 bits each; stall_cnt; stall_timeout. All are 0 after reset and asynchronously while reset is 0.
- Forwarding, combinational, per source s of way i:
  - If s == ZERO_REG, select RS.
  - Otherwise the youngest match wins: EX over MEM; within a stage the highest way index wins; valid entries only.
  - No match selects RS.
- Way i is blocked when id_valid[i] and any of:
  - a nonzero source has pend_cnt != 0; or
  - a nonzero source equals id_dest[j] of a valid earlier way j < i with id_dest[j] != ZERO_REG.
- issue_count = index of the first blocked way, else WAYS. Invalid ways never block.
- flush=1 forces issue_count = 0.
- Scoreboard update at the clock edge:
  - Every nonzero pend_cnt decrements by 1.
  - Then, for each way i < issue_count with id_valid, id_rd_mem and id_dest != ZERO_REG, pend_cnt[id_dest] = LOAD_LAT. The set overrides the decrement.
  - Duplicate dests in one group: same value, no conflict.
  - ZERO_REG is never set.
- Flush: at the edge all pend_cnt = 0, stall_cnt = 0, stall_timeout = 0. The issue set is ignored that cycle.
- Watchdog:
  - stall_cnt increments when id_valid[0] and issue_count == 0 and !flush; saturates at MAX_STALL.
  - Any issue or an invalid way 0 resets stall_cnt to 0.
  - stall_timeout sets on the edge where stall_cnt reaches MAX_STALL and holds until flush or reset.
- Latency: outputs are combinational on inputs plus state; there is no added pipeline delay.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cycles, perf_load_use, perf_intra_group, each 32-bit.
  - They count cycles with issue_count < WAYS and id_valid[issue_count]; blocks caused by the scoreboard; and blocks caused by same-group dependence. If both causes apply, both counters increment.
  - Reset to 0, wrap at 2^32, not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: enum FWD_SRC {FWD_RS=0, FWD_EX=1, FWD_MEM=2} (2 bits), ZERO_REG constant, LOAD_LAT_W = 3.
- One sub-module, fwd_select: one source register in, src/way out; instantiated 2 x WAYS via generate.
- Scoreboard, block logic and watchdog stay in the top module.

Test Plan:
- Load-use: cycle 0 way0 is a load to x5, issue 3. Cycle 1 way0 reads x5 -> issue_count 0. Cycle 2, with mem_dest[0]=5 valid -> issue_count 3, rs1_src=MEM, rs1_way=0.
- Intra-group: way0 dest x7, way2 rs2=x7, way1 independent -> issue_count 2. Way0 dest x7 read by way1 -> issue_count 1.
- Zero register: all ways write and read x0, with EX/MEM dest x0 -> issue_count 3, all selects RS, scoreboard unchanged.
- Priority: ex_dest[1]=3, ex_dest[0]=3, mem_dest[2]=3, way2 rs1=x3 -> rs1_src=EX, rs1_way=1.
- Flush and latency: LOAD_LAT=3, issue a load to x9, flush next edge -> the following cycle a read of x9 gives issue_count 3.
- Watchdog: MAX_STALL=4, hold a blocked way0 -> stall_timeout rises after the 4th stall edge and stays high until flush; asynchronous reset mid-stall clears it immediately.
